// File: rtl/data_hold_filter_if.sv
// Measurement hand-off between the measurement core and the hold filter.
interface data_hold_filter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] result_in;
  logic [WIDTH-1:0] result_out;
  logic             out_valid;
  logic             stale;
  logic [7:0]       rej_cnt;

  modport master (
    output in_valid, result_in,
    input  result_out, out_valid, stale, rej_cnt
  );

  modport slave (
    input  in_valid, result_in,
    output result_out, out_valid, stale, rej_cnt
  );
endinterface

// File: rtl/data_hold_filter.sv
// Holds the last in-range measurement and flags it stale after HOLD_MAX idle cycles; 1-cycle latency, no backpressure.
// DATA_HOLD_CLEAR_EN: result_out reads 0 while the held value is stale.
module data_hold_filter #(
  parameter int WIDTH     = 32,
  parameter int MIN_VALID = 1,
  parameter int HOLD_MAX  = 50_000_000
) (
  input logic              clk,
  input logic              rst_n,
  data_hold_filter_if.slave bus
);

  localparam int               AW      = $clog2(HOLD_MAX + 1);
  localparam logic [AW-1:0]    AGE_MAX = AW'(HOLD_MAX);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VALID);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_STALE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    age_q, age_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             stale_q, stale_d;
  logic [7:0]       rej_q, rej_d;
  logic             accept, reject;

  assign accept = bus.in_valid && (bus.result_in >= MIN_W);
  assign reject = bus.in_valid && !accept;

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    rej_d       = rej_q;
    if (accept) begin
      // Acceptance outranks the timeout even on the edge age would hit HOLD_MAX.
      state_d     = S_HOLD;
      age_d       = '0;
      result_d    = bus.result_in;
      out_valid_d = 1'b1;
      rej_d       = '0;
    end else begin
      if (reject && (rej_q != 8'hFF)) begin
        rej_d = rej_q + 8'd1;
      end
      case (state_q)
        S_HOLD: begin
          if (age_q >= AGE_MAX - AW'(1)) begin
            state_d = S_STALE;
            age_d   = AGE_MAX;
`ifdef DATA_HOLD_CLEAR_EN
            result_d = '0;
`else
            result_d = result_q;
`endif
          end else begin
            age_d = age_q + AW'(1);
          end
        end
        S_STALE: age_d = AGE_MAX;
        default: age_d = '0;
      endcase
    end
    stale_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      age_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      stale_q     <= 1'b1;
      rej_q       <= '0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      stale_q     <= stale_d;
      rej_q       <= rej_d;
    end
  end

  assign bus.result_out = result_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.stale      = stale_q;
  assign bus.rej_cnt    = rej_q;

endmodule

// File: tb/tb_data_hold_filter.sv
// Randomized and directed bench for data_hold_filter with a per-cycle expectation scoreboard.
module tb_data_hold_filter;

  localparam int WIDTH     = 32;
  localparam int MIN_VALID = 1;
  localparam int HOLD_MAX  = 8;
`ifdef DATA_HOLD_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ov;
    logic             st;
    logic [7:0]       rej;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state: what was last captured and how long ago.
  bit               m_have = 1'b0;
  logic [WIDTH-1:0] m_val  = '0;
  int               m_since = 0;
  int               m_rej   = 0;

  data_hold_filter_if #(.WIDTH(WIDTH)) bus ();

  data_hold_filter #(
    .WIDTH(WIDTH), .MIN_VALID(MIN_VALID), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d);
    exp_t e;
    rst_n         = r;
    bus.in_valid  = v;
    bus.result_in = d;
    if (!r) begin
      m_have = 1'b0; m_val = '0; m_since = 0; m_rej = 0; e.ov = 1'b0;
    end else if (v && d >= MIN_VALID) begin
      m_have = 1'b1; m_val = d; m_since = 0; m_rej = 0; e.ov = 1'b1;
    end else begin
      e.ov = 1'b0;
      if (v && m_rej < 255) m_rej++;
      if (m_have && m_since < HOLD_MAX) m_since++;
    end
    e.st  = !m_have || (m_since >= HOLD_MAX);
    e.res = (CLEAR && m_have && m_since >= HOLD_MAX) ? '0 : m_val;
    e.rej = 8'(m_rej);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  // Monitor: every edge yields one expected output snapshot.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.result_out !== e.res || bus.out_valid !== e.ov ||
            bus.stale !== e.st || bus.rej_cnt !== e.rej) begin
          n_bad++;
          $display("FAIL outputs cyc%0d: got res=%0d ov=%0b stale=%0b rej=%0d, want res=%0d ov=%0b stale=%0b rej=%0d",
                   cyc, bus.result_out, bus.out_valid, bus.stale, bus.rej_cnt,
                   e.res, e.ov, e.st, e.rej);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic v, r;
    // Scenario 1: reset then 20 idle cycles.
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'd77);
    idle(20);
    // Scenario 2: single accept.
    step(1'b1, 1'b1, 32'd1000);
    idle(2);
    // Scenario 3: three separated zero rejects, then accept 1500.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'd0);
      idle(1);
    end
    step(1'b1, 1'b1, 32'd1500);
    idle(1);
    // Scenario 4: timeout after HOLD_MAX idle edges, then linger in stale.
    step(1'b1, 1'b1, 32'd1000);
    idle(HOLD_MAX + 4);
    // Scenario 5: accept lands exactly on the timeout edge.
    step(1'b1, 1'b1, 32'd1000);
    idle(HOLD_MAX - 1);
    step(1'b1, 1'b1, 32'd2000);
    idle(HOLD_MAX + 1);
    // Minimum valid value and the top of the range.
    step(1'b1, 1'b1, 32'd1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    // Scenario 6: rejection saturation, then reset colliding with a sample.
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 32'd0);
    step(1'b0, 1'b1, 32'd500);
    idle(3);
    // Randomized phase: sparse strobes so stale periods occur, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = 32'($urandom_range(0, 2));
        default: d = $urandom;
      endcase
      step(r, v, d);
    end
    idle(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
